ibex_fetch_req_ctrl: RTL and testbench

//   Instruction-bus request controller sitting directly upstream of ibex_fetch_fifo.

---
 rtl/ibex_fetch_req_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
// ibex_fetch_req_ctrl: instruction-bus request controller feeding the fetch FIFO.
// Issues word-aligned requests and tracks outstanding transactions. On a branch it
// clears the FIFO, redirects fetching and drops the responses that are now stale.

// Protocol checker for the controller's bookkeeping.
module ibex_fetch_req_ctrl_chk #(
   parameter int unsigned NUM_REQS = 2,
   parameter int unsigned CW       = 2
) (
   input logic          clk_i,
   input logic          rst_ni,
   input logic          instr_rvalid_i,
   input logic [CW-1:0] outstanding_i
);

   // A response must always belong to an outstanding transaction.
   a_rvalid_has_outstanding: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      instr_rvalid_i |-> (outstanding_i != {CW{1'b0}})
   ) else $error("rvalid with no outstanding request");

   // The outstanding count is bounded by the FIFO capacity.
   a_outstanding_bound: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      outstanding_i <= CW'(NUM_REQS)
   ) else $error("outstanding count exceeds NUM_REQS");

endmodule

module ibex_fetch_req_ctrl #(
   parameter int unsigned NUM_REQS = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         addr_i,
   input  logic [NUM_REQS-1:0] fifo_busy_i,
   output logic                fifo_clear_o,
   output logic                fifo_valid_o,
   output logic [31:0]         fifo_addr_o,
   output logic [31:0]         fifo_rdata_o,
   output logic                fifo_err_o,
   output logic                instr_req_o,
   output logic [31:0]         instr_addr_o,
   input  logic                instr_gnt_i,
   input  logic                instr_rvalid_i,
   input  logic [31:0]         instr_rdata_i,
   input  logic                instr_err_i,
   output logic                busy_o
);

   localparam int unsigned CW = $clog2(NUM_REQS + 1);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_GNT = 1'b1
   } state_e;

   // Number of set bits in the FIFO occupancy vector.
   function automatic logic [CW-1:0] popcount(input logic [NUM_REQS-1:0] v);
      logic [CW-1:0] c;
      c = {CW{1'b0}};
      for (int i = 0; i < NUM_REQS; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   state_e        state_q, state_d;
   logic [31:0]   fetch_addr_q, fetch_addr_d;
   logic [31:0]   stored_addr_q, stored_addr_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic          wait_discard_q, wait_discard_d;

   logic [31:0]   branch_addr_s;
   logic          can_req_s;
   logic          gnt_acc_s;
   logic [CW-1:0] discard_base_s;

   assign branch_addr_s = {addr_i[31:2], 2'b00};

   // State register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         fetch_addr_q   <= 32'h0000_0000;
         stored_addr_q  <= 32'h0000_0000;
         outstanding_q  <= {CW{1'b0}};
         discard_q      <= {CW{1'b0}};
         wait_discard_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         fetch_addr_q   <= fetch_addr_d;
         stored_addr_q  <= stored_addr_d;
         outstanding_q  <= outstanding_d;
         discard_q      <= discard_d;
         wait_discard_q <= wait_discard_d;
      end
   end

   // Next-state logic: FSM transition, fetch address, outstanding and discard counters.
   always_comb begin
      state_d        = state_q;
      fetch_addr_d   = fetch_addr_q;
      stored_addr_d  = stored_addr_q;
      wait_discard_d = wait_discard_q;
      gnt_acc_s      = instr_req_o & instr_gnt_i;

      case (state_q)
         IDLE: begin
            wait_discard_d = 1'b0;
            if (gnt_acc_s) begin
               // Issued address (branch target or sequential) is accepted.
               fetch_addr_d = instr_addr_o + 32'd4;
            end else if (branch_i) begin
               fetch_addr_d = branch_addr_s;
            end else begin
               fetch_addr_d = fetch_addr_q;
            end
            if (instr_req_o && !instr_gnt_i) begin
               state_d       = WAIT_GNT;
               stored_addr_d = instr_addr_o;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_GNT: begin
            if (instr_gnt_i) begin
               state_d        = IDLE;
               wait_discard_d = 1'b0;
               if (branch_i) begin
                  fetch_addr_d = branch_addr_s;
               end else if (!wait_discard_q) begin
                  fetch_addr_d = stored_addr_q + 32'd4;
               end else begin
                  // Redirect already captured while waiting; keep the target.
                  fetch_addr_d = fetch_addr_q;
               end
            end else begin
               state_d        = WAIT_GNT;
               wait_discard_d = wait_discard_q | branch_i;
               if (branch_i) begin
                  fetch_addr_d = branch_addr_s;
               end else begin
                  fetch_addr_d = fetch_addr_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Every accepted request adds one, every response removes one.
      outstanding_d = outstanding_q + CW'(gnt_acc_s) - CW'(instr_rvalid_i);

      // On a branch everything still in flight becomes stale; otherwise drain.
      if (branch_i) begin
         discard_base_s = outstanding_q - CW'(instr_rvalid_i);
      end else if (instr_rvalid_i && (discard_q != {CW{1'b0}})) begin
         discard_base_s = discard_q - CW'(1'b1);
      end else begin
         discard_base_s = discard_q;
      end

      // A request granted after a redirect during WAIT_GNT is stale as well.
      if ((state_q == WAIT_GNT) && instr_gnt_i && (branch_i || wait_discard_q)) begin
         discard_d = discard_base_s + CW'(1'b1);
      end else begin
         discard_d = discard_base_s;
      end
   end

   // Output logic: bus request/address and FIFO-side signals.
   always_comb begin
      can_req_s    = (req_i | branch_i) &
                     (({1'b0, outstanding_q} + {1'b0, popcount(fifo_busy_i)}) < (CW+1)'(NUM_REQS));
      fifo_clear_o = branch_i;
      fifo_addr_o  = addr_i;
      fifo_rdata_o = instr_rdata_i;
      fifo_err_o   = instr_err_i;
      fifo_valid_o = instr_rvalid_i & ~branch_i & (discard_q == {CW{1'b0}});
      busy_o       = (state_q == WAIT_GNT) | (outstanding_q != {CW{1'b0}});

      case (state_q)
         IDLE: begin
            instr_req_o  = can_req_s;
            instr_addr_o = branch_i ? branch_addr_s : fetch_addr_q;
         end
         WAIT_GNT: begin
            // Address must stay stable until the grant, even across a branch.
            instr_req_o  = 1'b1;
            instr_addr_o = stored_addr_q;
         end
         default: begin
            instr_req_o  = 1'b0;
            instr_addr_o = 32'h0000_0000;
         end
      endcase
   end

   ibex_fetch_req_ctrl_chk #(
      .NUM_REQS (NUM_REQS),
      .CW       (CW)
   ) u_chk (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .instr_rvalid_i (instr_rvalid_i),
      .outstanding_i  (outstanding_q)
   );

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Self-checking bench for ibex_fetch_req_ctrl: directed bus scenarios with a
// scoreboard of expected FIFO pushes.
module tb_ibex_fetch_req_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        branch;
   logic [31:0] addr;
   logic [1:0]  fifo_busy;
   logic        fifo_clear;
   logic        fifo_valid;
   logic [31:0] fifo_addr;
   logic [31:0] fifo_rdata;
   logic        fifo_err;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt;
   logic        instr_rvalid;
   logic [31:0] instr_rdata;
   logic        instr_err;
   logic        busy;

   int checks_cnt   = 0;
   int failures_cnt = 0;

   logic [31:0] bus_q[$];   // granted addresses awaiting response
   logic [32:0] exp_q[$];   // expected {err, rdata} pushes into the FIFO

   ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_i          (req),
      .branch_i       (branch),
      .addr_i         (addr),
      .fifo_busy_i    (fifo_busy),
      .fifo_clear_o   (fifo_clear),
      .fifo_valid_o   (fifo_valid),
      .fifo_addr_o    (fifo_addr),
      .fifo_rdata_o   (fifo_rdata),
      .fifo_err_o     (fifo_err),
      .instr_req_o    (instr_req),
      .instr_addr_o   (instr_addr),
      .instr_gnt_i    (instr_gnt),
      .instr_rvalid_i (instr_rvalid),
      .instr_rdata_i  (instr_rdata),
      .instr_err_i    (instr_err),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         failures_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Drive one bus response for the oldest granted address.
   task automatic respond(input logic [31:0] exp_addr, input bit fwd, input bit err);
      logic [31:0] a;
      if (bus_q.size() > 0) begin
         a = bus_q[0];
         check_eq("rsp_order", a, exp_addr);
      end else begin
         check_eq("rsp_pending", bus_q.size(), 1);
         a = exp_addr;
      end
      instr_rvalid = 1'b1;
      instr_rdata  = data_of(a);
      instr_err    = err;
      if (fwd) exp_q.push_back({err, data_of(exp_addr)});
   endtask

   task automatic rsp_idle();
      instr_rvalid = 1'b0;
      instr_rdata  = 32'h0000_0000;
      instr_err    = 1'b0;
   endtask

   // Bus monitor: record grants, retire responses.
   always @(posedge clk) begin
      if (rst_n) begin
         if (instr_rvalid && bus_q.size() > 0) void'(bus_q.pop_front());
         if (instr_req && instr_gnt) bus_q.push_back(instr_addr);
      end
   end

   // Scoreboard: compare every FIFO push against the expected queue.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n && fifo_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_push", {31'd0, fifo_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("push_rdata", fifo_rdata, e[31:0]);
            check_eq("push_err", {31'd0, fifo_err}, {31'd0, e[32]});
         end
      end
   end

   initial begin
      rst_n = 1'b0; req = 1'b0; branch = 1'b0; addr = 32'h0;
      fifo_busy = 2'b00; instr_gnt = 1'b0;
      rsp_idle();
      tick(); tick();
      rst_n = 1'b1;
      settle();
      check_eq("rst_req", {31'd0, instr_req}, 32'd0);
      check_eq("rst_valid", {31'd0, fifo_valid}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);

      // Branch to 0x1002 with immediate grant.
      req = 1'b1; branch = 1'b1; addr = 32'h0000_1002; instr_gnt = 1'b1;
      settle();
      check_eq("br_addr", instr_addr, 32'h0000_1000);
      check_eq("br_req", {31'd0, instr_req}, 32'd1);
      check_eq("br_clear", {31'd0, fifo_clear}, 32'd1);
      check_eq("br_fifo_addr", fifo_addr, 32'h0000_1002);
      tick();
      branch = 1'b0; instr_gnt = 1'b0;
      respond(32'h0000_1000, 1'b1, 1'b0);
      settle();
      check_eq("seq_addr", instr_addr, 32'h0000_1004);
      tick();
      rsp_idle();

      // Grant withheld for 3 cycles: request must hold steady.
      for (int i = 0; i < 3; i++) begin
         settle();
         check_eq("wait_req", {31'd0, instr_req}, 32'd1);
         check_eq("wait_addr", instr_addr, 32'h0000_1004);
         tick();
      end
      instr_gnt = 1'b1;
      tick();
      settle();
      check_eq("seq2_addr", instr_addr, 32'h0000_1008);
      tick();
      instr_gnt = 1'b0;
      settle();
      check_eq("full_req", {31'd0, instr_req}, 32'd0);
      check_eq("full_busy", {31'd0, busy}, 32'd1);

      // Branch with 2 outstanding: both old responses are dropped.
      branch = 1'b1; addr = 32'h0000_2000;
      settle();
      check_eq("br2_clear", {31'd0, fifo_clear}, 32'd1);
      tick();
      branch = 1'b0;
      respond(32'h0000_1004, 1'b0, 1'b0);
      tick();
      respond(32'h0000_1008, 1'b0, 1'b0);
      tick();
      rsp_idle();
      settle();
      check_eq("br2_req", {31'd0, instr_req}, 32'd1);
      check_eq("br2_addr", instr_addr, 32'h0000_2000);
      instr_gnt = 1'b1;
      tick();
      instr_gnt = 1'b0; req = 1'b0;
      respond(32'h0000_2000, 1'b1, 1'b0);
      tick();
      rsp_idle();

      // Branch while waiting for a grant at 0x3000.
      branch = 1'b1; addr = 32'h0000_3000;
      settle();
      check_eq("br3_addr", instr_addr, 32'h0000_3000);
      tick();
      addr = 32'h0000_4002;
      settle();
      check_eq("wbr_addr", instr_addr, 32'h0000_3000);
      check_eq("wbr_clear", {31'd0, fifo_clear}, 32'd1);
      tick();
      branch = 1'b0; req = 1'b1;
      settle();
      check_eq("wbr_hold", instr_addr, 32'h0000_3000);
      instr_gnt = 1'b1;
      tick();
      settle();
      check_eq("tgt_req", {31'd0, instr_req}, 32'd1);
      check_eq("tgt_addr", instr_addr, 32'h0000_4000);
      tick();
      instr_gnt = 1'b0; req = 1'b0;
      respond(32'h0000_3000, 1'b0, 1'b0);
      tick();
      respond(32'h0000_4000, 1'b1, 1'b1);
      tick();
      rsp_idle();

      // FIFO full blocks requests; address wraps past 0xFFFF_FFFC.
      fifo_busy = 2'b11; branch = 1'b1; addr = 32'hFFFF_FFFC; req = 1'b1;
      settle();
      check_eq("ffull_br_req", {31'd0, instr_req}, 32'd0);
      tick();
      branch = 1'b0;
      settle();
      check_eq("ffull_req", {31'd0, instr_req}, 32'd0);
      tick();
      fifo_busy = 2'b01;
      settle();
      check_eq("fpart_req", {31'd0, instr_req}, 32'd1);
      check_eq("fpart_addr", instr_addr, 32'hFFFF_FFFC);
      instr_gnt = 1'b1;
      tick();
      fifo_busy = 2'b00;
      settle();
      check_eq("wrap_req", {31'd0, instr_req}, 32'd1);
      check_eq("wrap_addr", instr_addr, 32'h0000_0000);
      respond(32'hFFFF_FFFC, 1'b1, 1'b0);
      tick();
      instr_gnt = 1'b0; req = 1'b0;
      settle();
      check_eq("net_busy", {31'd0, busy}, 32'd1);
      respond(32'h0000_0000, 1'b1, 1'b0);
      tick();
      rsp_idle();
      settle();
      check_eq("drain_busy", {31'd0, busy}, 32'd0);

      // Reset mid-stream.
      req = 1'b1; instr_gnt = 1'b1;
      settle();
      check_eq("pre_rst_addr", instr_addr, 32'h0000_0004);
      tick();
      rst_n = 1'b0; req = 1'b0; instr_gnt = 1'b0;
      bus_q.delete();
      tick(); tick();
      check_eq("mrst_req", {31'd0, instr_req}, 32'd0);
      check_eq("mrst_busy", {31'd0, busy}, 32'd0);
      check_eq("mrst_valid", {31'd0, fifo_valid}, 32'd0);
      rst_n = 1'b1; req = 1'b1;
      settle();
      check_eq("post_rst_addr", instr_addr, 32'h0000_0000);
      check_eq("post_rst_req", {31'd0, instr_req}, 32'd1);
      req = 1'b0;
      tick(); tick();

      check_eq("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
      $finish;
   end

endmodule
